// File: rtl/picorv32_axi4_lite_master_bridge_if.sv
// AXI4-Lite master-port signal bundle between the picorv32 bridge and the interconnect.
// The master modport is the bridge side; the slave modport is the interconnect (or bench) side.
interface picorv32_axi4_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      axi_AWVALID;
    logic                      axi_AWREADY;
    logic [ADDR_WIDTH-1:0]     axi_AWADDR;
    logic                      axi_WVALID;
    logic                      axi_WREADY;
    logic [DATA_WIDTH-1:0]     axi_WDATA;
    logic [DATA_WIDTH/8-1:0]   axi_WSTRB;
    logic                      axi_BVALID;
    logic                      axi_BREADY;
    logic [1:0]                axi_BRESP;
    logic                      axi_ARVALID;
    logic                      axi_ARREADY;
    logic [ADDR_WIDTH-1:0]     axi_ARADDR;
    logic                      axi_RVALID;
    logic                      axi_RREADY;
    logic [DATA_WIDTH-1:0]     axi_RDATA;
    logic [1:0]                axi_RRESP;

    modport master (
        output axi_AWVALID, axi_AWADDR, axi_WVALID, axi_WDATA, axi_WSTRB, axi_BREADY,
               axi_ARVALID, axi_ARADDR, axi_RREADY,
        input  axi_AWREADY, axi_WREADY, axi_BVALID, axi_BRESP, axi_ARREADY,
               axi_RVALID, axi_RDATA, axi_RRESP
    );

    modport slave (
        input  axi_AWVALID, axi_AWADDR, axi_WVALID, axi_WDATA, axi_WSTRB, axi_BREADY,
               axi_ARVALID, axi_ARADDR, axi_RREADY,
        output axi_AWREADY, axi_WREADY, axi_BVALID, axi_BRESP, axi_ARREADY,
               axi_RVALID, axi_RDATA, axi_RRESP
    );
endinterface

// File: rtl/picorv32_axi4_lite_master_bridge.sv
// picorv32 native memory port to single AXI4-Lite master: one access in flight,
// one-cycle mem_ready, and a saturating timeout that completes accesses nobody answers.
module picorv32_axi4_lite_master_bridge #(
    parameter int                     ADDR_WIDTH     = 32,
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0]  ERR_RDATA      = '0
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      mem_valid,
    input  logic                      mem_instr,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    picorv32_axi4_lite_master_bridge_if.master axi,
    output logic                      bus_err,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic                      err_instr
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_instr;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_err;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [ADDR_WIDTH-1:0]     r_err_addr;
    logic                      r_err_instr;

    logic                      w_awvalid;
    logic                      w_wvalid;
    logic                      w_bready;
    logic                      w_arvalid;
    logic                      w_rready;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_busy;
    logic                      w_tmo;
    logic                      w_tmo_fire;
    logic                      w_err_set;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_busy  = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD) || (r_state == S_RD_DATA);
    // Fires on the last allowed busy cycle so VALID/READY are low from the next cycle on.
    assign w_tmo   = (TIMEOUT_CYCLES != 0) && (r_cnt >= TMO_LAST);
    assign w_aw_hs = w_awvalid && axi.axi_AWREADY;
    assign w_w_hs  = w_wvalid && axi.axi_WREADY;

    always_comb begin
        w_next     = r_state;
        w_tmo_fire = 1'b0;
        w_err_set  = 1'b0;
        w_awvalid  = (r_state == S_WR) && !r_aw_done;
        w_wvalid   = (r_state == S_WR) && !r_w_done;
        w_bready   = (r_state == S_WR_RESP);
        w_arvalid  = (r_state == S_RD);
        w_rready   = (r_state == S_RD_DATA);
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_next = (|mem_wstrb) ? S_WR : S_RD;
                end
            end
            S_WR: begin
                // A handshake completing the phase beats a simultaneous timeout.
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = S_WR_RESP;
                end else if (w_tmo) begin
                    w_next     = S_DONE;
                    w_tmo_fire = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (axi.axi_BVALID) begin
                    w_next    = S_DONE;
                    w_err_set = |axi.axi_BRESP;
                end else if (w_tmo) begin
                    w_next     = S_DONE;
                    w_tmo_fire = 1'b1;
                end
            end
            S_RD: begin
                if (axi.axi_ARREADY) begin
                    w_next = S_RD_DATA;
                end else if (w_tmo) begin
                    w_next     = S_DONE;
                    w_tmo_fire = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (axi.axi_RVALID) begin
                    w_next    = S_DONE;
                    w_err_set = |axi.axi_RRESP;
                end else if (w_tmo) begin
                    w_next     = S_DONE;
                    w_tmo_fire = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_tmo_fire) begin
            w_err_set = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_instr     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_err_addr  <= '0;
            r_err_instr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_cnt     <= '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_err     <= 1'b0;
                if (mem_valid) begin
                    r_addr  <= mem_addr;
                    r_wdata <= mem_wdata;
                    r_wstrb <= mem_wstrb;
                    r_instr <= mem_instr;
                end
            end else if (w_busy) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            // Error address is captured on entry to DONE so it is visible alongside bus_err.
            if (w_err_set) begin
                r_err       <= 1'b1;
                r_err_addr  <= r_addr;
                r_err_instr <= r_instr;
            end
            if (w_tmo_fire) begin
                r_rdata <= ERR_RDATA;
            end else if ((r_state == S_RD_DATA) && axi.axi_RVALID) begin
                r_rdata <= (|axi.axi_RRESP) ? ERR_RDATA : axi.axi_RDATA;
            end
        end
    end

    assign mem_ready       = (r_state == S_DONE);
    assign bus_err         = (r_state == S_DONE) && r_err;
    assign mem_rdata       = r_rdata;
    assign err_addr        = r_err_addr;
    assign err_instr       = r_err_instr;

    assign axi.axi_AWVALID = w_awvalid;
    assign axi.axi_AWADDR  = r_addr;
    assign axi.axi_WVALID  = w_wvalid;
    assign axi.axi_WDATA   = r_wdata;
    assign axi.axi_WSTRB   = r_wstrb;
    assign axi.axi_BREADY  = w_bready;
    assign axi.axi_ARVALID = w_arvalid;
    assign axi.axi_ARADDR  = r_addr;
    assign axi.axi_RREADY  = w_rready;
endmodule

// File: tb/tb_picorv32_axi4_lite_master_bridge.sv
// Bench for the picorv32 AXI4-Lite bridge: table of transactions against a
// configurable-wait slave, a scoreboard of expected completions, plus reset and back-to-back sequences.
module tb_picorv32_axi4_lite_master_bridge;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, bus_err, err_instr;
    logic [31:0] mem_rdata, err_addr;

    picorv32_axi4_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if ();

    picorv32_axi4_lite_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .ERR_RDATA(32'h0000_0000)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .axi(axi_if),
        .bus_err(bus_err), .err_addr(err_addr), .err_instr(err_instr)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          instr;
        int          aw_w, w_w, b_w, ar_w, r_w;
        bit          noready;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_wonly;
    } vec_t;

    typedef struct {
        int          lat;
        bit          wr;
        bit          noready;
        logic [31:0] rdata;
        bit          err;
        int          wonly;
        logic [31:0] addr;
        bit          instr;
    } exp_t;

    exp_t sb[$];
    vec_t vt[9];
    vec_t vx;

    int checks = 0;
    int errors = 0;
    int t_req;
    logic [31:0] m_err_addr = '0;
    bit          m_err_instr = 0;

    // Slave configuration and observation counters
    int          s_aw_wait, s_w_wait, s_b_wait, s_ar_wait, s_r_wait;
    bit          s_noready;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    int aw_seen, w_seen, b_seen, ar_seen, r_seen;
    int aw_hs, w_hs, b_hs, ar_hs, r_hs, w_only, both_viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: READY/VALID are driven on the falling edge from counts of cycles the request has waited.
    initial begin
        axi_if.axi_AWREADY = 0; axi_if.axi_WREADY = 0; axi_if.axi_ARREADY = 0;
        axi_if.axi_BVALID = 0;  axi_if.axi_BRESP = 0;
        axi_if.axi_RVALID = 0;  axi_if.axi_RRESP = 0; axi_if.axi_RDATA = 0;
        aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0; both_viol = 0;
        forever begin
            @(negedge iCLK);
            if (axi_if.axi_AWVALID && axi_if.axi_ARVALID) both_viol++;
            if (axi_if.axi_WVALID && !axi_if.axi_AWVALID) w_only++;
            if (axi_if.axi_AWVALID) begin
                axi_if.axi_AWREADY = !s_noready && (aw_seen == s_aw_wait);
                if (axi_if.axi_AWREADY) aw_hs++;
                aw_seen++;
            end else begin
                axi_if.axi_AWREADY = 0; aw_seen = 0;
            end
            if (axi_if.axi_WVALID) begin
                axi_if.axi_WREADY = !s_noready && (w_seen == s_w_wait);
                if (axi_if.axi_WREADY) w_hs++;
                w_seen++;
            end else begin
                axi_if.axi_WREADY = 0; w_seen = 0;
            end
            if (axi_if.axi_ARVALID) begin
                axi_if.axi_ARREADY = !s_noready && (ar_seen == s_ar_wait);
                if (axi_if.axi_ARREADY) ar_hs++;
                ar_seen++;
            end else begin
                axi_if.axi_ARREADY = 0; ar_seen = 0;
            end
            if (axi_if.axi_BREADY) begin
                axi_if.axi_BVALID = (b_seen == s_b_wait);
                axi_if.axi_BRESP  = axi_if.axi_BVALID ? s_resp : 2'b00;
                if (axi_if.axi_BVALID) b_hs++;
                b_seen++;
            end else begin
                axi_if.axi_BVALID = 0; axi_if.axi_BRESP = 0; b_seen = 0;
            end
            if (axi_if.axi_RREADY) begin
                axi_if.axi_RVALID = (r_seen == s_r_wait);
                axi_if.axi_RRESP  = axi_if.axi_RVALID ? s_resp : 2'b00;
                axi_if.axi_RDATA  = axi_if.axi_RVALID ? s_rdata : 32'h0;
                if (axi_if.axi_RVALID) r_hs++;
                r_seen++;
            end else begin
                axi_if.axi_RVALID = 0; axi_if.axi_RRESP = 0; axi_if.axi_RDATA = 0; r_seen = 0;
            end
        end
    end

    task automatic start_txn(input vec_t v, input bit b2b);
        exp_t e;
        s_aw_wait = v.aw_w; s_w_wait = v.w_w; s_b_wait = v.b_w;
        s_ar_wait = v.ar_w; s_r_wait = v.r_w;
        s_noready = v.noready; s_resp = v.resp; s_rdata = v.rdata;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; w_only = 0;
        mem_valid = 1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wr ? v.wstrb : 4'h0;
        mem_instr = v.instr;
        // In a back-to-back request the DUT samples it in the IDLE cycle after DONE.
        t_req = b2b ? cyc + 1 : cyc;
        e.lat = v.lat; e.wr = v.wr; e.noready = v.noready; e.rdata = v.exp_rdata;
        e.err = v.exp_err; e.wonly = v.exp_wonly; e.addr = v.addr; e.instr = v.instr;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        bit   got;
        n = 0; got = 0;
        while (n < 100 && !got) begin
            @(negedge iCLK);
            n++;
            if (mem_ready) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_ready: no mem_ready within 100 cycles, expected one", tag);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(cyc - t_req), 32'(e.lat));
        check({tag, "_bus_err"}, 32'(bus_err), 32'(e.err));
        if (!e.wr) check({tag, "_rdata"}, mem_rdata, e.rdata);
        check({tag, "_handshakes_idle_in_done"},
              32'({axi_if.axi_AWVALID, axi_if.axi_WVALID, axi_if.axi_BREADY,
                   axi_if.axi_ARVALID, axi_if.axi_RREADY}), 32'h0);
        if (e.wr) begin
            check({tag, "_aw_w_b_count"}, 32'({aw_hs[3:0], w_hs[3:0], b_hs[3:0]}),
                  e.noready ? 32'h000 : 32'h111);
            check({tag, "_wvalid_only_cycles"}, 32'(w_only), 32'(e.wonly));
        end else begin
            check({tag, "_ar_r_count"}, 32'({ar_hs[3:0], r_hs[3:0]}),
                  e.noready ? 32'h00 : 32'h11);
        end
        if (e.err) begin
            m_err_addr  = e.addr;
            m_err_instr = e.instr;
        end
    endtask

    task automatic post_check(input string tag);
        mem_valid = 0;
        @(negedge iCLK);
        check({tag, "_single_ready"}, 32'({mem_ready, bus_err}), 32'h0);
        check({tag, "_err_addr"}, err_addr, m_err_addr);
        check({tag, "_err_instr"}, 32'(err_instr), 32'(m_err_instr));
    endtask

    initial begin
        int n;
        int pulses;
        iRST = 1; mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        s_aw_wait = 0; s_w_wait = 0; s_b_wait = 0; s_ar_wait = 0; s_r_wait = 0;
        s_noready = 0; s_resp = 0; s_rdata = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; w_only = 0;

        //           wr addr          wdata          wstrb  in aw w  b  ar r  nr resp   rdata          lat exp_rdata      err wonly
        vt[0] = '{1, 32'h0001_0010, 32'hCAFE_BABE, 4'hF,  0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,          3, 32'h0,          0, 0};
        vt[1] = '{0, 32'h0002_0004, 32'h0,         4'h0,  0, 0, 0, 0, 2, 2, 0, 2'b00, 32'h1234_5678,  7, 32'h1234_5678,  0, 0};
        vt[2] = '{1, 32'h0001_0014, 32'h0BAD_F00D, 4'hF,  0, 0, 3, 0, 0, 0, 0, 2'b00, 32'h0,          6, 32'h0,          0, 3};
        vt[3] = '{0, 32'h0003_0000, 32'h0,         4'h0,  0, 0, 0, 0, 0, 0, 1, 2'b00, 32'h1111_1111, 17, 32'h0,          1, 0};
        vt[4] = '{0, 32'h0002_0008, 32'h0,         4'h0,  1, 0, 0, 0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF,  3, 32'h0,          1, 0};
        vt[5] = '{1, 32'h0001_0020, 32'h5555_AAAA, 4'hF,  0, 0, 0, 1, 0, 0, 0, 2'b10, 32'h0,          4, 32'h0,          1, 0};
        vt[6] = '{1, 32'h0002_0010, 32'h0000_BEEF, 4'h3,  0, 2, 0, 0, 0, 0, 0, 2'b00, 32'h0,          5, 32'h0,          0, 0};
        vt[7] = '{0, 32'h0000_0100, 32'h0,         4'h0,  1, 0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_5A5A,  3, 32'hA5A5_5A5A,  0, 0};
        vt[8] = '{1, 32'h0004_0000, 32'hFFFF_FFFF, 4'hF,  0, 0, 0, 0, 0, 0, 1, 2'b00, 32'h0,         17, 32'h0,          1, 0};

        repeat (3) @(negedge iCLK);
        check("reset_ctl", 32'({mem_ready, bus_err, err_instr, axi_if.axi_AWVALID, axi_if.axi_WVALID,
                                axi_if.axi_BREADY, axi_if.axi_ARVALID, axi_if.axi_RREADY}), 32'h0);
        check("reset_data", mem_rdata | err_addr | axi_if.axi_AWADDR | axi_if.axi_ARADDR |
                            axi_if.axi_WDATA | 32'(axi_if.axi_WSTRB), 32'h0);
        iRST = 0;
        @(negedge iCLK);

        for (int i = 0; i < 9; i++) begin
            start_txn(vt[i], 0);
            wait_done($sformatf("vec%0d", i));
            post_check($sformatf("vec%0d", i));
        end

        // Errored read immediately followed by a write requested during the DONE cycle
        vx = vt[4];
        vx.addr = 32'h0002_0018;
        start_txn(vx, 0);
        wait_done("b2b_err_read");
        vx = vt[0];
        vx.addr = 32'h0001_0030; vx.wdata = 32'h0F0F_0F0F;
        start_txn(vx, 1);
        wait_done("b2b_write");
        post_check("b2b_write");
        check("b2b_err_addr_kept", err_addr, 32'h0002_0018);

        // Reset while waiting in the read-data phase
        vx = vt[7];
        vx.addr = 32'h0002_000C; vx.r_w = 20; vx.instr = 0;
        start_txn(vx, 0);
        n = 0;
        while (n < 20 && !axi_if.axi_RREADY) begin
            @(negedge iCLK);
            n++;
        end
        check("rst_mid_reached_rd_data", 32'(axi_if.axi_RREADY), 32'h1);
        iRST = 1;
        @(negedge iCLK);
        check("rst_mid_ctl", 32'({mem_ready, bus_err, err_instr, axi_if.axi_AWVALID, axi_if.axi_WVALID,
                                  axi_if.axi_BREADY, axi_if.axi_ARVALID, axi_if.axi_RREADY}), 32'h0);
        check("rst_mid_data", mem_rdata | err_addr, 32'h0);
        iRST = 0;
        mem_valid = 0;
        sb.delete();
        m_err_addr = '0;
        m_err_instr = 0;
        pulses = 0;
        repeat (6) begin
            @(negedge iCLK);
            if (mem_ready) pulses++;
        end
        check("rst_mid_no_ready", 32'(pulses), 32'h0);
        start_txn(vt[7], 0);
        wait_done("after_rst_read");
        post_check("after_rst_read");

        check("aw_ar_exclusive", 32'(both_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
